// File: rtl/bus_interface_pkg.sv
// Shared constants and types for bus_interface: register window layout,
// TIMER_CTRL bit positions and the captured CPU write payload.
package bus_interface_pkg;

    localparam int unsigned WINDOW_SIZE = 8;

    // Register offsets inside the window
    localparam logic [2:0] REG_PENDING    = 3'd0;
    localparam logic [2:0] REG_MASK       = 3'd1;
    localparam logic [2:0] REG_RAW        = 3'd2;
    localparam logic [2:0] REG_TIMER_LO   = 3'd3;
    localparam logic [2:0] REG_TIMER_HI   = 3'd4;
    localparam logic [2:0] REG_TIMER_CTRL = 3'd5;

    // TIMER_CTRL bit indices
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;

    // One captured CPU write
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } cpu_wr_t;

endpackage

// File: rtl/cpu_write_sync.sv
// Synchronises the asynchronous 6502 write strobe and turns each completed
// write into a one-cycle pulse carrying the captured address and data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cpu_address     CPU address bus
//   data_in         CPU write data
//   write_enable_B  asynchronous active-low write strobe
//   wr_strobe       one-cycle pulse per completed write
//   wr_addr/wr_data captured write, valid while wr_strobe is high
module cpu_write_sync
    import bus_interface_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  data_in,
    input  logic        write_enable_B,
    output logic        wr_strobe,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   armed;
    logic                   we_s;
    cpu_wr_t                cap_q;

    assign we_s = sync_q[SYNC_STAGES-1];

    // Synchroniser, capture while the strobe is low, pulse on its release
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            armed     <= 1'b0;
            wr_strobe <= 1'b0;
            cap_q     <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], write_enable_B};
            wr_strobe <= 1'b0;
            if (!we_s) begin
                cap_q <= '{addr: cpu_address, data: data_in};
                armed <= 1'b1;
            end else if (armed) begin
                // armed guarantees the low phase was seen since reset
                wr_strobe <= 1'b1;
                armed     <= 1'b0;
            end
        end
    end

    assign wr_addr = cap_q.addr;
    assign wr_data = cap_q.data;

endmodule

// File: rtl/bus_interface.sv
// CPU bus glue: clean write pulses from the 6502 strobe plus a multi-source
// interrupt controller (pending / mask / write-1-to-clear) driving irq_B.
// Optional 16-bit interval timer as an extra IRQ source when the macro
// BUS_TIMER_IRQ_EN is defined.
// Ports:
//   clk_12_5875, rst   clock, synchronous active-high reset
//   cpu_address        CPU address bus
//   data_in            CPU write data
//   write_enable_B     asynchronous active-low CPU write strobe
//   data_out           window read data, 0 outside the window (combinational)
//   fpga_data_enable   read enable for the window (combinational)
//   irq_src            IRQ requests, rising-edge sensitive, bit0 = vblank
//   irq_B              active-low CPU IRQ (registered)
//   wr_strobe          one-cycle pulse per completed CPU write
//   wr_addr, wr_data   captured write, valid with wr_strobe
module bus_interface
    import bus_interface_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [15:0] IRQ_BASE    = 16'h7010,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_12_5875,
    input  logic               rst,
    input  logic [15:0]        cpu_address,
    input  logic [7:0]         data_in,
    input  logic               write_enable_B,
    output logic [7:0]         data_out,
    output logic               fpga_data_enable,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               irq_B,
    output logic               wr_strobe,
    output logic [15:0]        wr_addr,
    output logic [7:0]         wr_data
);

`ifdef BUS_TIMER_IRQ_EN
    localparam int unsigned TMR_W = 1;
`else
    localparam int unsigned TMR_W = 0;
`endif
    localparam int unsigned PEND_W = NUM_IRQ + TMR_W;

    logic [PEND_W-1:0]  pending;
    logic [PEND_W-1:0]  mask;
    logic [PEND_W-1:0]  set_bits;
    logic [PEND_W-1:0]  clr_bits;
    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] src_rise;
    logic [15:0]        wr_off;
    logic [15:0]        rd_off;
    logic [2:0]         wr_reg;
    logic               wr_hit;
    logic               rd_hit;
    logic [7:0]         rd_val;

    cpu_write_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cpu_write_sync (
        .clk            (clk_12_5875),
        .rst            (rst),
        .cpu_address    (cpu_address),
        .data_in        (data_in),
        .write_enable_B (write_enable_B),
        .wr_strobe      (wr_strobe),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data)
    );

    // Window decode; subtracting the base keeps unaligned bases correct
    assign wr_off   = wr_addr - IRQ_BASE;
    assign wr_hit   = wr_strobe && (wr_off < 16'(WINDOW_SIZE));
    assign wr_reg   = wr_off[2:0];
    assign rd_off   = cpu_address - IRQ_BASE;
    assign rd_hit   = rd_off < 16'(WINDOW_SIZE);

    assign src_rise = irq_src & ~src_q;
    assign clr_bits = (wr_hit && (wr_reg == REG_PENDING)) ? wr_data[PEND_W-1:0] : '0;

`ifdef BUS_TIMER_IRQ_EN
    logic [15:0] reload;
    logic [15:0] count;
    logic        tmr_en;
    logic        tmr_auto;
    logic        tmr_fire;

    assign tmr_fire = tmr_en && (count == 16'd0);
    assign set_bits = {tmr_fire, src_rise};

    // Down-counter: reload N gives one fire every N+1 cycles
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            reload   <= '0;
            count    <= '0;
            tmr_en   <= 1'b0;
            tmr_auto <= 1'b0;
        end else begin
            if (wr_hit && (wr_reg == REG_TIMER_LO)) reload[7:0]  <= wr_data;
            if (wr_hit && (wr_reg == REG_TIMER_HI)) reload[15:8] <= wr_data;
            if (wr_hit && (wr_reg == REG_TIMER_CTRL)) begin
                tmr_en   <= wr_data[CTRL_EN_BIT];
                tmr_auto <= wr_data[CTRL_AUTO_BIT];
                if (wr_data[CTRL_EN_BIT]) count <= reload;
            end else if (tmr_en) begin
                if (count == 16'd0) begin
                    if (tmr_auto) count  <= reload;
                    else          tmr_en <= 1'b0;
                end else begin
                    count <= count - 16'd1;
                end
            end
        end
    end
`else
    assign set_bits = src_rise;
`endif

    // Pending (set wins over W1C), mask and the registered IRQ line
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
            src_q   <= '0;
            irq_B   <= 1'b1;
        end else begin
            src_q   <= irq_src;
            pending <= (pending & ~clr_bits) | set_bits;
            if (wr_hit && (wr_reg == REG_MASK)) mask <= wr_data[PEND_W-1:0];
            irq_B   <= ~|(pending & mask);
        end
    end

    // Read mux over registered state
    always_comb begin
        rd_val = 8'h00;
        case (rd_off[2:0])
            REG_PENDING:    rd_val = 8'(pending);
            REG_MASK:       rd_val = 8'(mask);
            REG_RAW:        rd_val = 8'(irq_src);
`ifdef BUS_TIMER_IRQ_EN
            REG_TIMER_LO:   rd_val = reload[7:0];
            REG_TIMER_HI:   rd_val = reload[15:8];
            REG_TIMER_CTRL: rd_val = 8'({tmr_auto, tmr_en});
`endif
            default:        rd_val = 8'h00;
        endcase
    end

    assign data_out         = rd_hit ? rd_val : 8'h00;
    assign fpga_data_enable = write_enable_B && rd_hit;

endmodule

// File: tb/tb_bus_interface.sv
module tb_bus_interface;

    localparam logic [15:0] BASE  = 16'h7010;
    localparam int unsigned NSRC  = 4;

    logic            clk_12_5875 = 1'b0;
    logic            rst;
    logic [15:0]     cpu_address;
    logic [7:0]      data_in;
    logic            write_enable_B;
    logic [7:0]      data_out;
    logic            fpga_data_enable;
    logic [NSRC-1:0] irq_src;
    logic            irq_B;
    logic            wr_strobe;
    logic [15:0]     wr_addr;
    logic [7:0]      wr_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_prev;

    bus_interface #(
        .NUM_IRQ     (NSRC),
        .IRQ_BASE    (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk_12_5875      (clk_12_5875),
        .rst              (rst),
        .cpu_address      (cpu_address),
        .data_in          (data_in),
        .write_enable_B   (write_enable_B),
        .data_out         (data_out),
        .fpga_data_enable (fpga_data_enable),
        .irq_src          (irq_src),
        .irq_B            (irq_B),
        .wr_strobe        (wr_strobe),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data)
    );

    always #5 clk_12_5875 = ~clk_12_5875;
    always @(posedge clk_12_5875) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Combinational window read, called just after a falling edge
    task automatic read_reg(input logic [2:0] off, output logic [7:0] val);
        cpu_address    = BASE + 16'(off);
        write_enable_B = 1'b1;
        #1;
        val = data_out;
    endtask

    // Full CPU write; returns at the falling edge where wr_strobe is visible,
    // s_edge is the index of the rising edge that consumes it
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int s_edge);
        @(negedge clk_12_5875);
        cpu_address    = a;
        data_in        = d;
        write_enable_B = 1'b0;
        repeat (6) @(negedge clk_12_5875);
        write_enable_B = 1'b1;
        s_edge = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_12_5875);
            if (wr_strobe) begin
                s_edge = cyc + 1;
                break;
            end
        end
        n_cmp++;
        if (s_edge < 0) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h: no wr_strobe within 10 cycles, required one", a);
        end
    endtask

    function automatic logic fired_between(input int s, input int lo, input int hi);
        for (int f = s + 4; f <= hi; f += 4)
            if (f >= lo) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        logic [7:0] v;
        n_cmp += 4;
        if (irq_B !== 1'b1)      begin n_fail++; $display("FAIL reset_irq_B got=%b exp=1", irq_B); end
        if (wr_strobe !== 1'b0)  begin n_fail++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
        if (wr_addr !== 16'h0)   begin n_fail++; $display("FAIL reset_wr_addr got=%h exp=0000", wr_addr); end
        if (wr_data !== 8'h0)    begin n_fail++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        for (int o = 0; o < 8; o++) begin
            if (o == 2) continue;
            read_reg(3'(o), v);
            n_cmp++;
            if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d got=%h exp=00", o, v); end
        end
        n_cmp++;
        if (fpga_data_enable !== 1'b1) begin n_fail++; $display("FAIL enable_in_window got=%b exp=1", fpga_data_enable); end
        write_enable_B = 1'b0;
        #1;
        n_cmp++;
        if (fpga_data_enable !== 1'b0) begin n_fail++; $display("FAIL enable_during_write got=%b exp=0", fpga_data_enable); end
        write_enable_B = 1'b1;
        cpu_address    = 16'h1234;
        #1;
        n_cmp += 2;
        if (fpga_data_enable !== 1'b0) begin n_fail++; $display("FAIL enable_outside got=%b exp=0", fpga_data_enable); end
        if (data_out !== 8'h00)        begin n_fail++; $display("FAIL data_outside got=%h exp=00", data_out); end
    endtask

    task automatic test_write_capture();
        int cnt = 0;
        int first = -1;
        @(negedge clk_12_5875);
        cpu_address    = 16'h0123;
        data_in        = 8'hA5;
        write_enable_B = 1'b0;
        repeat (6) @(negedge clk_12_5875);
        write_enable_B = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_12_5875);
            if (wr_strobe) begin
                if (first < 0) begin
                    first = i;
                    n_cmp += 2;
                    if (wr_addr !== 16'h0123) begin n_fail++; $display("FAIL cap_addr got=%h exp=0123", wr_addr); end
                    if (wr_data !== 8'hA5)    begin n_fail++; $display("FAIL cap_data got=%h exp=a5", wr_data); end
                end
                cnt++;
            end
        end
        n_cmp += 2;
        if (cnt !== 1)   begin n_fail++; $display("FAIL cap_count got=%0d exp=1", cnt); end
        if (first !== 2) begin n_fail++; $display("FAIL cap_latency got=%0d exp=2 (3 edges after release)", first); end
    endtask

    task automatic test_irq_assert_clear();
        int s;
        logic [7:0] v;
        cpu_write(BASE + 16'd1, 8'h01, s);
        m_mask = 8'h01;
        @(negedge clk_12_5875);
        irq_src = 4'b0001;
        @(negedge clk_12_5875);
        read_reg(3'd0, v);
        n_cmp += 2;
        if (v !== 8'h01)    begin n_fail++; $display("FAIL irq_pending got=%h exp=01", v); end
        if (irq_B !== 1'b1) begin n_fail++; $display("FAIL irq_B_edge+1 got=%b exp=1", irq_B); end
        @(negedge clk_12_5875);
        n_cmp++;
        if (irq_B !== 1'b0) begin n_fail++; $display("FAIL irq_B_edge+2 got=%b exp=0", irq_B); end
        irq_src = 4'b0000;
        cpu_write(BASE, 8'h01, s);
        @(negedge clk_12_5875);
        n_cmp++;
        if (irq_B !== 1'b0) begin n_fail++; $display("FAIL irq_B_w1c+1 got=%b exp=0", irq_B); end
        @(negedge clk_12_5875);
        read_reg(3'd0, v);
        n_cmp += 2;
        if (irq_B !== 1'b1) begin n_fail++; $display("FAIL irq_B_w1c+2 got=%b exp=1", irq_B); end
        if (v !== 8'h00)    begin n_fail++; $display("FAIL w1c_pending got=%h exp=00", v); end
        m_pend = 8'h00;
        m_prev = 8'h00;
    endtask

    task automatic test_collision();
        int s;
        logic [7:0] v;
        @(negedge clk_12_5875);
        irq_src = 4'b0010;
        @(negedge clk_12_5875);
        irq_src = 4'b0000;
        @(negedge clk_12_5875);
        cpu_write(BASE, 8'h02, s);
        irq_src = 4'b0010;
        @(negedge clk_12_5875);
        read_reg(3'd0, v);
        n_cmp++;
        if (v !== 8'h02) begin n_fail++; $display("FAIL collision_set_wins got=%h exp=02", v); end
        cpu_write(BASE, 8'h02, s);
        @(negedge clk_12_5875);
        read_reg(3'd0, v);
        n_cmp++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL collision_followup_clear got=%h exp=00", v); end
        irq_src = 4'b0000;
        m_prev  = 8'h00;
        m_pend  = 8'h00;
    endtask

    task automatic test_masked();
        int s;
        logic [7:0] v;
        cpu_write(BASE + 16'd1, 8'h00, s);
        m_mask = 8'h00;
        @(negedge clk_12_5875);
        irq_src = 4'hF;
        @(negedge clk_12_5875);
        read_reg(3'd0, v);
        n_cmp++;
        if (v !== 8'h0F) begin n_fail++; $display("FAIL masked_pending got=%h exp=0f", v); end
        @(negedge clk_12_5875);
        read_reg(3'd2, v);
        n_cmp += 2;
        if (irq_B !== 1'b1) begin n_fail++; $display("FAIL masked_irq_B got=%b exp=1", irq_B); end
        if (v !== 8'h0F)    begin n_fail++; $display("FAIL raw_all got=%h exp=0f", v); end
        irq_src = 4'h5;
        read_reg(3'd2, v);
        n_cmp++;
        if (v !== 8'h05) begin n_fail++; $display("FAIL raw_5 got=%h exp=05", v); end
        irq_src = 4'h0;
        cpu_write(BASE, 8'hFF, s);
        @(negedge clk_12_5875);
        read_reg(3'd0, v);
        n_cmp++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL masked_clear got=%h exp=00", v); end
        m_pend = 8'h00;
        m_prev = 8'h00;
    endtask

    // Random sources, masks and W1C checked against the pending/mask rules
    task automatic test_random();
        int s;
        logic [7:0] v;
        logic [7:0] r;
        logic [7:0] c;
        for (int it = 0; it < 12; it++) begin
            r = 8'($urandom_range(0, 15));
            cpu_write(BASE + 16'd1, r, s);
            m_mask = r;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk_12_5875);
                r = 8'($urandom_range(0, 15));
                irq_src = r[NSRC-1:0];
                read_reg(3'd2, v);
                n_cmp++;
                if (v !== r) begin n_fail++; $display("FAIL rnd_raw it=%0d got=%h exp=%h", it, v, r); end
                m_pend = m_pend | (r & ~m_prev);
                m_prev = r;
                @(negedge clk_12_5875);
                read_reg(3'd0, v);
                n_cmp++;
                if (v !== m_pend) begin n_fail++; $display("FAIL rnd_pending it=%0d got=%h exp=%h", it, v, m_pend); end
                @(negedge clk_12_5875);
                n_cmp++;
                if (irq_B !== ~|(m_pend & m_mask))
                    begin n_fail++; $display("FAIL rnd_irq_B it=%0d got=%b exp=%b", it, irq_B, ~|(m_pend & m_mask)); end
            end
            read_reg(3'd1, v);
            n_cmp++;
            if (v !== m_mask) begin n_fail++; $display("FAIL rnd_mask it=%0d got=%h exp=%h", it, v, m_mask); end
            c = 8'($urandom);
            cpu_write(BASE, c, s);
            m_pend = m_pend & ~c;
            @(negedge clk_12_5875);
            read_reg(3'd0, v);
            n_cmp++;
            if (v !== m_pend) begin n_fail++; $display("FAIL rnd_w1c it=%0d got=%h exp=%h", it, v, m_pend); end
            @(negedge clk_12_5875);
            n_cmp++;
            if (irq_B !== ~|(m_pend & m_mask))
                begin n_fail++; $display("FAIL rnd_w1c_irq_B it=%0d got=%b exp=%b", it, irq_B, ~|(m_pend & m_mask)); end
        end
        irq_src = '0;
        cpu_write(BASE, 8'hFF, s);
        cpu_write(BASE + 16'd1, 8'h00, s);
        m_pend = 8'h00;
        m_mask = 8'h00;
        m_prev = 8'h00;
    endtask

`ifdef BUS_TIMER_IRQ_EN
    task automatic test_timer();
        int s;
        int w;
        logic [7:0] v;
        logic exp;
        cpu_write(BASE + 16'd3, 8'h03, s);
        cpu_write(BASE + 16'd4, 8'h00, s);
        @(negedge clk_12_5875);
        read_reg(3'd3, v);
        n_cmp++;
        if (v !== 8'h03) begin n_fail++; $display("FAIL timer_reload_lo got=%h exp=03", v); end
        // one-shot
        cpu_write(BASE + 16'd5, 8'h01, s);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_12_5875);
            read_reg(3'd0, v);
            exp = (cyc >= s + 4);
            n_cmp++;
            if (v[4] !== exp) begin n_fail++; $display("FAIL oneshot_bit4 cyc=%0d got=%b exp=%b", cyc - s, v[4], exp); end
        end
        read_reg(3'd5, v);
        n_cmp++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL oneshot_ctrl got=%h exp=00", v); end
        cpu_write(BASE, 8'h10, s);
        // auto-reload
        cpu_write(BASE + 16'd5, 8'h03, s);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_12_5875);
            read_reg(3'd0, v);
            exp = (cyc >= s + 4);
            n_cmp++;
            if (v[4] !== exp) begin n_fail++; $display("FAIL auto_first_bit4 cyc=%0d got=%b exp=%b", cyc - s, v[4], exp); end
        end
        cpu_write(BASE, 8'h10, w);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_12_5875);
            read_reg(3'd0, v);
            exp = fired_between(s, w, cyc);
            n_cmp++;
            if (v[4] !== exp) begin n_fail++; $display("FAIL auto_refire_bit4 cyc=%0d got=%b exp=%b", cyc - s, v[4], exp); end
        end
        cpu_write(BASE + 16'd5, 8'h00, s);
        cpu_write(BASE, 8'h10, s);
    endtask
`else
    task automatic test_no_timer();
        int s;
        logic [7:0] v;
        for (int o = 3; o < 6; o++) cpu_write(BASE + 16'(o), 8'hFF, s);
        @(negedge clk_12_5875);
        for (int o = 3; o < 8; o++) begin
            read_reg(3'(o), v);
            n_cmp++;
            if (v !== 8'h00) begin n_fail++; $display("FAIL notimer_reg%0d got=%h exp=00", o, v); end
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        int s;
        int cnt = 0;
        logic [7:0] v;
        cpu_write(BASE + 16'd1, 8'h0F, s);
        @(negedge clk_12_5875);
        irq_src = 4'b0100;
        repeat (2) @(negedge clk_12_5875);
        n_cmp++;
        if (irq_B !== 1'b0) begin n_fail++; $display("FAIL premid_irq_B got=%b exp=0", irq_B); end
        irq_src        = 4'b0000;
        cpu_address    = BASE + 16'd1;
        data_in        = 8'hFF;
        write_enable_B = 1'b0;
        repeat (4) @(negedge clk_12_5875);
        rst = 1'b1;
        @(negedge clk_12_5875);
        write_enable_B = 1'b1;
        repeat (3) @(negedge clk_12_5875);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_12_5875);
            if (wr_strobe) cnt++;
        end
        n_cmp += 4;
        if (cnt !== 0)         begin n_fail++; $display("FAIL mid_strobes got=%0d exp=0", cnt); end
        if (irq_B !== 1'b1)    begin n_fail++; $display("FAIL mid_irq_B got=%b exp=1", irq_B); end
        if (wr_addr !== 16'h0) begin n_fail++; $display("FAIL mid_wr_addr got=%h exp=0000", wr_addr); end
        if (wr_data !== 8'h0)  begin n_fail++; $display("FAIL mid_wr_data got=%h exp=00", wr_data); end
        for (int o = 0; o < 8; o++) begin
            if (o == 2) continue;
            read_reg(3'(o), v);
            n_cmp++;
            if (v !== 8'h00) begin n_fail++; $display("FAIL mid_reg%0d got=%h exp=00", o, v); end
        end
    endtask

    initial begin
        rst            = 1'b1;
        cpu_address    = 16'h0000;
        data_in        = 8'h00;
        write_enable_B = 1'b1;
        irq_src        = '0;
        m_pend         = 8'h00;
        m_mask         = 8'h00;
        m_prev         = 8'h00;
        repeat (3) @(negedge clk_12_5875);
        rst = 1'b0;

        test_reset();
        test_write_capture();
        test_irq_assert_clear();
        test_collision();
        test_masked();
        test_random();
`ifdef BUS_TIMER_IRQ_EN
        test_timer();
`else
        test_no_timer();
`endif
        test_reset_mid_write();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_interface.md
# bus_interface

Parametrised successor to the fixed top-level glue: it turns the asynchronous 6502 write strobe into a single-cycle, clean write pulse on `clk_12_5875`, and adds a multi-source interrupt controller (pending/mask/W1C) that replaces the single hard-wired vblank IRQ. It sits between the CPU bus pins and the FPGA peripherals (GPU, controllers, optional timer). It drives the shared active-low IRQ line and the FPGA's own read data for its register window.

## Interface
- `NUM_IRQ`, 4: number of external IRQ sources, 1..8 (1..7 when `BUS_TIMER_IRQ_EN` is defined).
- `IRQ_BASE`, 16'h7010: base address of the 8-byte register window.
- `SYNC_STAGES`, 2: flip-flops in the write-strobe synchroniser, ≥2.

Ports:
- `clk_12_5875`  in  1  system clock.
- `rst`  in  1  **one clock; reset is synchronous and active-high**.
- `cpu_address`  in  16  CPU address bus.
- `data_in`  in  8  CPU write data.
- `write_enable_B`  in  1  CPU write strobe, active low, asynchronous.
- `data_out`  out  8  read data for the window; 8'h00 outside it.
- `fpga_data_enable`  out  1  high when `write_enable_B`=1 and the address is inside the window.
- `irq_src`  in  NUM_IRQ  synchronous IRQ requests, rising-edge sensitive; bit0 = vblank.
- `irq_B`  out  1  active-low CPU IRQ, registered.
- `wr_strobe`  out  1  one-cycle pulse per completed CPU write.
- `wr_addr`  out  16  captured write address, valid when `wr_strobe` is high.
- `wr_data`  out  8  captured write data, valid when `wr_strobe` is high.

## Operation
- **Write capture.** `write_enable_B` passes through `SYNC_STAGES` flops (reset value 1) to give `we_s`.
  - While `we_s`=0: `cpu_address` and `data_in` are registered every cycle and the `armed` flag is set.
  - When `we_s` goes 0→1 with `armed` set: `wr_strobe` pulses for one cycle with the last captured values, and `armed` clears.
  - A write whose assertion was never observed after reset produces no strobe.
- **Register window.** Offsets from `IRQ_BASE`:
  - +0 PENDING: read; writing 1 to a bit clears it.
  - +1 MASK: read/write.
  - +2 RAW: read-only, current `irq_src` levels.
  - +3 TIMER_LO, +4 TIMER_HI: read/write reload value.
  - +5 TIMER_CTRL: bit0 enable, bit1 auto-reload.
  - +6, +7: read 0.
  - Registers update on the edge where `wr_strobe`=1 and `wr_addr` hits the register.
- **Read path.** `data_out` and `fpga_data_enable` are combinational from `cpu_address` and `write_enable_B`, muxing already-registered values. Bits ≥ pending width read 0.
- **Pending.**
  - `pending[i]` sets on a rising edge of `irq_src[i]`, detected against a registered previous value (reset 0).
  - When a set and a W1C clear hit the same bit in the same cycle, the set wins.
- **IRQ output.** `irq_B` is the registered value of `~|(pending & mask)`.
- **Reset values.**
  - Outputs: `irq_B`=1, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0.
  - Internal state: pending, mask, timer registers and `armed` all 0.
  - Reset in the middle of a write discards that write.

## Timing
- A pin deassertion produces `wr_strobe` exactly `SYNC_STAGES`+1 cycles later.
- The minimum CPU strobe low time is `SYNC_STAGES`+1 cycles. Shorter pulses may be lost; this is acceptable and documented.
- A register write is visible on `data_out` the cycle after `wr_strobe`.
- From an `irq_src` rising edge:
  - `pending` is set 1 cycle later.
  - `irq_B` falls 2 cycles later, if the bit is masked in.
- A W1C of the last active bit releases `irq_B` 2 cycles after `wr_strobe`.
- Timer (when compiled in):
  - Writing TIMER_CTRL with enable=1 loads `count` from the reload value.
  - Each cycle: if enabled and `count`=0, set the timer pending bit, then reload if auto-reload is set, else clear enable; otherwise decrement.
  - Reload N fires every N+1 cycles.

## Configuration
- `BUS_TIMER_IRQ_EN` defined:
  - Adds the 16-bit down-counter.
  - Pending and mask are NUM_IRQ+1 bits wide; bit NUM_IRQ is the timer.
  - Offsets +3..+5 are live.
- `BUS_TIMER_IRQ_EN` undefined:
  - No counter logic.
  - Offsets +3..+5 read 0 and ignore writes.
  - Pending and mask are NUM_IRQ bits wide.

## Structure
- Package `bus_interface_pkg` holds:
  - the register offset constants (`REG_PENDING` … `REG_TIMER_CTRL`);
  - the TIMER_CTRL bit indices;
  - the window size of 8.
- Sub-module `cpu_write_sync` contains the synchroniser, capture registers, `armed` flag and `wr_strobe` generation.
- The top of the block holds decode, registers, IRQ logic and the timer.

## Test plan
- **Write capture.** Hold `write_enable_B` low for 6 cycles with addr 16'h0123, data 8'hA5, then release → exactly one `wr_strobe` 3 cycles after release, carrying 16'h0123/8'hA5.
- **IRQ assert and clear.** Write MASK=8'h01, pulse `irq_src[0]` → PENDING reads 8'h01 and `irq_B` goes low 2 cycles after the edge. W1C 8'h01 to +0 → `irq_B` high 2 cycles after the strobe.
- **Set/clear collision.** A W1C of bit1 lands in the same cycle as an `irq_src[1]` rising edge → bit1 remains set.
- **Masked source.** MASK=0 with all sources pulsed → PENDING=8'h0F and `irq_B` stays 1. RAW tracks the input levels.
- **Timer.** With `BUS_TIMER_IRQ_EN`, NUM_IRQ=4: reload=3, CTRL=8'h03 → pending bit4 sets every 4 cycles. With CTRL=8'h01 it fires once, then enable reads 0.
- **Reset mid-write.** Assert `rst` while `write_enable_B` is low, then release the strobe → no `wr_strobe`, all registers 0, `irq_B`=1.
